// File: rtl/topo_game_ctrl_if.sv
// Signal bundle between the whack-a-mole game controller and the board/display side.
interface topo_game_ctrl_if;
  logic       START;
  logic       HIT;
  logic [3:0] N_CELDA_PONER_TOPO;
  logic       PONER_TOPO;
  logic [7:0] SCORE;
  logic [7:0] TIME_LEFT;
  logic       RUNNING;
  logic       GAME_OVER;

  modport master (
    input  START, HIT,
    output N_CELDA_PONER_TOPO, PONER_TOPO, SCORE, TIME_LEFT, RUNNING, GAME_OVER
  );

  modport slave (
    output START, HIT,
    input  N_CELDA_PONER_TOPO, PONER_TOPO, SCORE, TIME_LEFT, RUNNING, GAME_OVER
  );
endinterface

// File: rtl/topo_game_ctrl.sv
// Whack-a-mole game controller: game timing, pseudo-random mole placement and
// hit scoring. The LFSR free-runs in every state so the start time seeds the game.
module topo_game_ctrl #(
  parameter int unsigned TICK_DIV    = 25000000,
  parameter int unsigned SPAWN_TICKS = 2,
  parameter int unsigned GAME_TICKS  = 60,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic             Clock,
  input  logic             reset,
  topo_game_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_e;

  localparam int unsigned TW         = $clog2(TICK_DIV);
  localparam int unsigned SW         = $clog2(SPAWN_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SPAWN_LAST = SW'(SPAWN_TICKS - 1);
  localparam logic [7:0]  GT         = 8'(GAME_TICKS);
  localparam logic [15:0] SEED       = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] TAPS       = 16'hB400;

  state_e        state_q;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [TW-1:0] tick_cnt_q;
  logic [SW-1:0] spawn_cnt_q;
  logic          hit_dly_q;
  logic [3:0]    cell_q, cell_d;
  logic          poner_q;
  logic [7:0]    score_q;
  logic [7:0]    time_q;
  logic          running_q;
  logic          over_q;

  logic          hit_rise;
  logic          tick;
  logic [3:0]    cand;

  always_comb begin
    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : '0);
    hit_rise = bus.HIT & ~hit_dly_q;
    tick     = (tick_cnt_q == TICK_LAST);
    cand     = lfsr_q[3:0];
    cell_d   = (cand == cell_q) ? cand + 4'd1 : cand;
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED;
      tick_cnt_q  <= '0;
      spawn_cnt_q <= '0;
      hit_dly_q   <= 1'b0;
      cell_q      <= '0;
      poner_q     <= 1'b0;
      score_q     <= '0;
      time_q      <= GT;
      running_q   <= 1'b0;
      over_q      <= 1'b0;
    end else begin
      lfsr_q    <= lfsr_d;
      hit_dly_q <= bus.HIT;
      poner_q   <= 1'b0;
      case (state_q)
        IDLE, OVER: begin
          if (bus.START) begin
            state_q     <= RUN;
            score_q     <= '0;
            time_q      <= GT;
            tick_cnt_q  <= '0;
            spawn_cnt_q <= '0;
            running_q   <= 1'b1;
            over_q      <= 1'b0;
          end
        end
        RUN: begin
          if (hit_rise && (score_q != 8'hFF)) score_q <= score_q + 8'd1;
          if (tick) begin
            tick_cnt_q <= '0;
            time_q     <= time_q - 8'd1;
            // The final tick ends the game and suppresses that tick's spawn.
            if (time_q == 8'd1) begin
              state_q   <= OVER;
              running_q <= 1'b0;
              over_q    <= 1'b1;
            end else if (spawn_cnt_q == SPAWN_LAST) begin
              spawn_cnt_q <= '0;
              poner_q     <= 1'b1;
              cell_q      <= cell_d;
            end else begin
              spawn_cnt_q <= spawn_cnt_q + SW'(1);
            end
          end else begin
            tick_cnt_q <= tick_cnt_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.N_CELDA_PONER_TOPO = cell_q;
  assign bus.PONER_TOPO         = poner_q;
  assign bus.SCORE              = score_q;
  assign bus.TIME_LEFT          = time_q;
  assign bus.RUNNING            = running_q;
  assign bus.GAME_OVER          = over_q;

endmodule

// File: tb/tb_topo_game_ctrl.sv
// Bench for topo_game_ctrl: game-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_topo_game_ctrl;
  localparam int TD = 4;
  localparam int SP = 2;
  localparam int GT = 5;
  localparam logic [15:0] SEED = 16'hACE1;

  logic Clock = 1'b0;
  logic reset;
  always #5 Clock = ~Clock;

  topo_game_ctrl_if b0();
  topo_game_ctrl_if b1();

  topo_game_ctrl #(.TICK_DIV(TD), .SPAWN_TICKS(SP), .GAME_TICKS(GT), .LFSR_SEED(SEED))
    u0 (.Clock(Clock), .reset(reset), .bus(b0));
  topo_game_ctrl #(.TICK_DIV(TD), .SPAWN_TICKS(SP), .GAME_TICKS(255), .LFSR_SEED(SEED))
    u1 (.Clock(Clock), .reset(reset), .bus(b1));

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // Smallest idle delay before START that makes the first spawn candidate equal prev.
  function automatic int find_collide(input logic [15:0] l, input logic [3:0] prev);
    logic [15:0] v;
    v = l;
    for (int i = 0; i < TD * SP; i++) v = lfsr_step(v);
    for (int d = 0; d < 64; d++) begin
      if (v[3:0] == prev) return d;
      v = lfsr_step(v);
    end
    return -1;
  endfunction

  // Game-level model: phase 0 idle, 1 run, 2 over; m_c is the RUN cycle index.
  int          m_ph, m_c, m_score;
  logic        m_prev_hit, m_pulse;
  logic [15:0] m_lfsr;
  logic [3:0]  m_cell;
  int          k_now;
  logic        tk_now, fin_now, spn_now;

  assign k_now   = m_c / TD + 1;
  assign tk_now  = (m_c % TD) == (TD - 1);
  assign fin_now = tk_now && (k_now == GT);
  assign spn_now = tk_now && !fin_now && ((k_now % SP) == 0);

  always @(posedge Clock or negedge reset) begin
    if (!reset) begin
      m_ph <= 0; m_c <= 0; m_score <= 0; m_prev_hit <= 1'b0;
      m_pulse <= 1'b0; m_lfsr <= SEED; m_cell <= 4'd0;
    end else begin
      m_prev_hit <= b0.HIT;
      m_lfsr     <= lfsr_step(m_lfsr);
      if (m_ph == 1) begin
        if (b0.HIT && !m_prev_hit && m_score < 255) m_score <= m_score + 1;
        if (fin_now) m_ph <= 2;
        else m_c <= m_c + 1;
        if (spn_now) m_cell <= (m_lfsr[3:0] == m_cell) ? m_lfsr[3:0] + 4'd1 : m_lfsr[3:0];
        m_pulse <= spn_now;
      end else begin
        m_pulse <= 1'b0;
        if (b0.START) begin m_ph <= 1; m_c <= 0; m_score <= 0; end
      end
    end
  end

  always @(negedge Clock) begin
    if (reset && cmp_en) begin
      chk("m_RUNNING",   int'(b0.RUNNING),    int'(m_ph == 1));
      chk("m_GAME_OVER", int'(b0.GAME_OVER),  int'(m_ph == 2));
      chk("m_TIME_LEFT", int'(b0.TIME_LEFT),  (m_ph == 0) ? GT : (m_ph == 1) ? GT - m_c / TD : 0);
      chk("m_SCORE",     int'(b0.SCORE),      m_score);
      chk("m_PONER",     int'(b0.PONER_TOPO), int'(m_pulse));
      chk("m_CELL",      int'(b0.N_CELDA_PONER_TOPO), int'(m_cell));
    end
  end

  logic [3:0] last_cell;
  always @(negedge Clock or negedge reset) begin
    if (!reset) last_cell <= 4'd0;
    else if (b0.PONER_TOPO) begin
      chk("spawn_cell_repeat", int'(b0.N_CELDA_PONER_TOPO != last_cell), 1);
      last_cell <= b0.N_CELDA_PONER_TOPO;
    end
  end

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  int np, dd, d;
  logic [3:0] ec;
  bit forced;

  initial begin
    b0.START = 1'b0; b0.HIT = 1'b0; b1.START = 1'b0; b1.HIT = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    chk("rst_SCORE", int'(b0.SCORE), 0);
    chk("rst_TIME_LEFT", int'(b0.TIME_LEFT), 5);
    chk("rst_RUNNING", int'(b0.RUNNING), 0);
    chk("rst_GAME_OVER", int'(b0.GAME_OVER), 0);
    chk("rst_PONER", int'(b0.PONER_TOPO), 0);
    chk("rst_CELL", int'(b0.N_CELDA_PONER_TOPO), 0);
    chk("rst_u1_TIME_LEFT", int'(b1.TIME_LEFT), 255);
    @(posedge Clock);
    #2 reset = 1'b1;
    cmp_en = 1'b1;
    cyc();

    // A: HIT held high from IDLE into RUN; basic timing of ticks and spawns.
    b0.HIT = 1'b1;
    cyc(); cyc();
    b0.START = 1'b1; cyc(); b0.START = 1'b0;
    np = 0;
    for (int c = 0; c < 22; c++) begin
      if (c == 6) b0.HIT = 1'b0;
      @(negedge Clock);
      if (b0.PONER_TOPO) np++;
      if (c == 0) begin
        chk("A_entry_RUNNING", int'(b0.RUNNING), 1);
        chk("A_entry_TIME_LEFT", int'(b0.TIME_LEFT), 5);
      end
      if (c == 3) chk("A_tl_before_tick", int'(b0.TIME_LEFT), 5);
      if (c == 4) chk("A_tl_after_tick", int'(b0.TIME_LEFT), 4);
      if (c == 8 || c == 16) chk("A_pulse_slot", int'(b0.PONER_TOPO), 1);
      if (c == 19) begin
        chk("A_tl_19", int'(b0.TIME_LEFT), 1);
        chk("A_over_19", int'(b0.GAME_OVER), 0);
      end
      if (c == 20) begin
        chk("A_over_20", int'(b0.GAME_OVER), 1);
        chk("A_tl_20", int'(b0.TIME_LEFT), 0);
        chk("A_held_hit_score", int'(b0.SCORE), 0);
      end
      cyc();
    end
    chk("A_pulse_count", np, 2);

    // B: restart from OVER, START held during RUN, hits incl. one on the final tick.
    b0.START = 1'b1; cyc();
    for (int c = 0; c < 22; c++) begin
      b0.START = (c <= 10);
      b0.HIT = (c >= 2 && c <= 4) || (c >= 6 && c <= 8) || (c >= 10 && c <= 12) || (c == 19);
      @(negedge Clock);
      if (c == 0) begin
        chk("B_entry_SCORE", int'(b0.SCORE), 0);
        chk("B_entry_TIME_LEFT", int'(b0.TIME_LEFT), 5);
        chk("B_entry_RUNNING", int'(b0.RUNNING), 1);
      end
      if (c == 11) begin
        chk("B_no_restart_RUNNING", int'(b0.RUNNING), 1);
        chk("B_no_restart_TIME_LEFT", int'(b0.TIME_LEFT), 3);
      end
      if (c == 13) chk("B_score_3", int'(b0.SCORE), 3);
      if (c == 20) begin
        chk("B_final_tick_hit_SCORE", int'(b0.SCORE), 4);
        chk("B_over_20", int'(b0.GAME_OVER), 1);
      end
      if (c == 21) chk("B_over_hold_SCORE", int'(b0.SCORE), 4);
      cyc();
    end
    b0.START = 1'b0; b0.HIT = 1'b0;

    // C: restart clears score, then asynchronous reset mid-RUN at cycle 9.
    b0.START = 1'b1; cyc(); b0.START = 1'b0;
    for (int c = 0; c < 10; c++) begin
      b0.HIT = (c >= 2 && c <= 4);
      @(negedge Clock);
      if (c == 0) begin
        chk("C_restart_SCORE", int'(b0.SCORE), 0);
        chk("C_restart_TIME_LEFT", int'(b0.TIME_LEFT), 5);
        chk("C_restart_RUNNING", int'(b0.RUNNING), 1);
        chk("C_restart_GAME_OVER", int'(b0.GAME_OVER), 0);
      end
      if (c == 6) chk("C_score_1", int'(b0.SCORE), 1);
      if (c < 9) cyc();
    end
    #1 reset = 1'b0;
    #1;
    chk("C_arst_RUNNING", int'(b0.RUNNING), 0);
    chk("C_arst_SCORE", int'(b0.SCORE), 0);
    chk("C_arst_TIME_LEFT", int'(b0.TIME_LEFT), 5);
    chk("C_arst_CELL", int'(b0.N_CELDA_PONER_TOPO), 0);
    chk("C_arst_PONER", int'(b0.PONER_TOPO), 0);
    cyc();
    chk("C_arst_hold_PONER", int'(b0.PONER_TOPO), 0);
    chk("C_arst_hold_GAME_OVER", int'(b0.GAME_OVER), 0);
    #1 reset = 1'b1;
    cyc();
    b0.START = 1'b1; cyc(); b0.START = 1'b0;
    for (int c = 0; c < 22; c++) begin
      @(negedge Clock);
      if (c == 0) begin
        chk("C_post_rst_SCORE", int'(b0.SCORE), 0);
        chk("C_post_rst_RUNNING", int'(b0.RUNNING), 1);
      end
      if (c == 8) chk("C_post_rst_pulse", int'(b0.PONER_TOPO), 1);
      cyc();
    end

    // D: 50 games, even ones timed so the first spawn candidate repeats prev_cell.
    for (int g = 0; g < 50; g++) begin
      forced = 1'b0;
      ec = 4'd0;
      d = int'($urandom_range(0, 5));
      if (g % 2 == 0) begin
        dd = find_collide(m_lfsr, m_cell);
        if (dd >= 0) begin
          d = dd;
          forced = 1'b1;
          ec = m_cell + 4'd1;
        end
      end
      repeat (d) cyc();
      b0.START = 1'b1; cyc(); b0.START = 1'b0;
      for (int c = 0; c < 22; c++) begin
        b0.HIT = 1'($urandom_range(0, 1));
        @(negedge Clock);
        if (forced && c == 8) chk("D_collision_cell", int'(b0.N_CELDA_PONER_TOPO), int'(ec));
        cyc();
      end
    end
    b0.HIT = 1'b0;

    // E: 300 hit edges in a 255-tick game saturate SCORE at 255.
    b1.START = 1'b1; cyc(); b1.START = 1'b0;
    for (int e = 1; e <= 300; e++) begin
      b1.HIT = 1'b1; cyc();
      b1.HIT = 1'b0; cyc();
      if (e == 100 || e == 254 || e == 255 || e == 300)
        chk("E_score_edges", int'(b1.SCORE), (e < 255) ? e : 255);
    end
    repeat (10) cyc();
    chk("E_score_stays", int'(b1.SCORE), 255);
    chk("E_still_RUNNING", int'(b1.RUNNING), 1);
    chk("E_TIME_LEFT", int'(b1.TIME_LEFT), 103);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
